// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Round-robin sharing of one integer ALU between two requesters,
//            with operand capture, busy wait-out and per-port kill.
// Revision : 1.0
// ============================================================================
`default_nettype none

module alu_arbiter #(
    parameter int DW  = 32,
    parameter int OPW = 5
) (
    input  logic           I_clk,
    input  logic           I_reset_n,
    // port A
    input  logic           I_a_req,
    input  logic [OPW-1:0] I_a_op,
    input  logic [DW-1:0]  I_a_s1,
    input  logic [DW-1:0]  I_a_s2,
    input  logic           I_a_kill,
    output logic           O_a_gnt,
    output logic           O_a_valid,
    output logic [DW-1:0]  O_a_data,
    output logic           O_a_lt,
    output logic           O_a_ltu,
    output logic           O_a_eq,
    // port B
    input  logic           I_b_req,
    input  logic [OPW-1:0] I_b_op,
    input  logic [DW-1:0]  I_b_s1,
    input  logic [DW-1:0]  I_b_s2,
    input  logic           I_b_kill,
    output logic           O_b_gnt,
    output logic           O_b_valid,
    output logic [DW-1:0]  O_b_data,
    output logic           O_b_lt,
    output logic           O_b_ltu,
    output logic           O_b_eq,
    // ALU side
    output logic           O_alu_en,
    output logic [OPW-1:0] O_alu_op,
    output logic [DW-1:0]  O_alu_s1,
    output logic [DW-1:0]  O_alu_s2,
    input  logic           I_alu_busy,
    input  logic [DW-1:0]  I_alu_data,
    input  logic           I_alu_lt,
    input  logic           I_alu_ltu,
    input  logic           I_alu_eq,
    output logic           O_idle
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;   // 0 = A, 1 = B
    logic           rr_q, rr_d;         // 0 = A preferred on contention
    logic           kill_q, kill_d;
    logic [OPW-1:0] op_q, op_d;
    logic [DW-1:0]  s1_q, s1_d;
    logic [DW-1:0]  s2_q, s2_d;

    logic           a_valid_q, b_valid_q;
    logic [DW-1:0]  a_data_q, b_data_q;
    logic           a_lt_q, a_ltu_q, a_eq_q;
    logic           b_lt_q, b_ltu_q, b_eq_q;

    logic w_idle, w_a_eff, w_b_eff, w_gnt_a, w_gnt_b;
    logic w_owner_kill, w_capture, w_drop, w_a_load, w_b_load;

    assign w_idle  = (state_q == S_IDLE);
    assign w_a_eff = I_a_req & ~I_a_kill;
    assign w_b_eff = I_b_req & ~I_b_kill;
    assign w_gnt_a = w_idle & w_a_eff & (~w_b_eff | ~rr_q);
    assign w_gnt_b = w_idle & w_b_eff & (~w_a_eff |  rr_q);

    // A kill arriving in the capture cycle itself must still suppress the result
    assign w_owner_kill = owner_q ? I_b_kill : I_a_kill;
    assign w_capture    = (state_q == S_WAIT) & ~I_alu_busy;
    assign w_drop       = kill_q | w_owner_kill;
    assign w_a_load     = w_capture & ~w_drop & ~owner_q;
    assign w_b_load     = w_capture & ~w_drop &  owner_q;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_d     = rr_q;
        kill_d   = kill_q;
        op_d     = op_q;
        s1_d     = s1_q;
        s2_d     = s2_q;
        O_alu_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                if (w_gnt_a || w_gnt_b) begin
                    owner_d = w_gnt_b;
                    rr_d    = w_gnt_a;
                    op_d    = w_gnt_b ? I_b_op : I_a_op;
                    s1_d    = w_gnt_b ? I_b_s1 : I_a_s1;
                    s2_d    = w_gnt_b ? I_b_s2 : I_a_s2;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                O_alu_en = 1'b1;
                if (w_owner_kill) kill_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (w_owner_kill) kill_d = 1'b1;
                if (!I_alu_busy) begin
                    kill_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            rr_q    <= 1'b0;
            kill_q  <= 1'b0;
            op_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            kill_q  <= kill_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
        end
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            a_valid_q <= 1'b0;
            b_valid_q <= 1'b0;
            a_data_q  <= '0;
            b_data_q  <= '0;
            a_lt_q    <= 1'b0;
            a_ltu_q   <= 1'b0;
            a_eq_q    <= 1'b0;
            b_lt_q    <= 1'b0;
            b_ltu_q   <= 1'b0;
            b_eq_q    <= 1'b0;
        end else begin
            a_valid_q <= w_a_load;
            b_valid_q <= w_b_load;
            if (w_a_load) begin
                a_data_q <= I_alu_data;
                a_lt_q   <= I_alu_lt;
                a_ltu_q  <= I_alu_ltu;
                a_eq_q   <= I_alu_eq;
            end
            if (w_b_load) begin
                b_data_q <= I_alu_data;
                b_lt_q   <= I_alu_lt;
                b_ltu_q  <= I_alu_ltu;
                b_eq_q   <= I_alu_eq;
            end
        end
    end

    assign O_a_gnt   = w_gnt_a;
    assign O_b_gnt   = w_gnt_b;
    assign O_a_valid = a_valid_q;
    assign O_a_data  = a_data_q;
    assign O_a_lt    = a_lt_q;
    assign O_a_ltu   = a_ltu_q;
    assign O_a_eq    = a_eq_q;
    assign O_b_valid = b_valid_q;
    assign O_b_data  = b_data_q;
    assign O_b_lt    = b_lt_q;
    assign O_b_ltu   = b_ltu_q;
    assign O_b_eq    = b_eq_q;
    assign O_alu_op  = op_q;
    assign O_alu_s1  = s1_q;
    assign O_alu_s2  = s2_q;
    assign O_idle    = w_idle;

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Purpose  : Scoreboard bench for alu_arbiter with a behavioural ALU model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int DW  = 32;
    localparam int OPW = 5;
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_SUB = 5'd1;
    localparam logic [4:0] OP_OR  = 5'd2;
    localparam logic [4:0] OP_SLL = 5'd3;
    localparam logic [4:0] OP_SRA = 5'd4;

    logic           I_clk = 1'b0;
    logic           I_reset_n;
    logic           I_a_req, I_a_kill, I_b_req, I_b_kill;
    logic [OPW-1:0] I_a_op, I_b_op;
    logic [DW-1:0]  I_a_s1, I_a_s2, I_b_s1, I_b_s2;
    logic           O_a_gnt, O_a_valid, O_a_lt, O_a_ltu, O_a_eq;
    logic           O_b_gnt, O_b_valid, O_b_lt, O_b_ltu, O_b_eq;
    logic [DW-1:0]  O_a_data, O_b_data;
    logic           O_alu_en, O_idle;
    logic [OPW-1:0] O_alu_op;
    logic [DW-1:0]  O_alu_s1, O_alu_s2;
    logic           I_alu_busy, I_alu_lt, I_alu_ltu, I_alu_eq;
    logic [DW-1:0]  I_alu_data;

    alu_arbiter #(.DW(DW), .OPW(OPW)) dut (
        .I_clk(I_clk), .I_reset_n(I_reset_n),
        .I_a_req(I_a_req), .I_a_op(I_a_op), .I_a_s1(I_a_s1), .I_a_s2(I_a_s2),
        .I_a_kill(I_a_kill), .O_a_gnt(O_a_gnt), .O_a_valid(O_a_valid),
        .O_a_data(O_a_data), .O_a_lt(O_a_lt), .O_a_ltu(O_a_ltu), .O_a_eq(O_a_eq),
        .I_b_req(I_b_req), .I_b_op(I_b_op), .I_b_s1(I_b_s1), .I_b_s2(I_b_s2),
        .I_b_kill(I_b_kill), .O_b_gnt(O_b_gnt), .O_b_valid(O_b_valid),
        .O_b_data(O_b_data), .O_b_lt(O_b_lt), .O_b_ltu(O_b_ltu), .O_b_eq(O_b_eq),
        .O_alu_en(O_alu_en), .O_alu_op(O_alu_op), .O_alu_s1(O_alu_s1),
        .O_alu_s2(O_alu_s2), .I_alu_busy(I_alu_busy), .I_alu_data(I_alu_data),
        .I_alu_lt(I_alu_lt), .I_alu_ltu(I_alu_ltu), .I_alu_eq(I_alu_eq),
        .O_idle(O_idle)
    );

    always #5 I_clk = ~I_clk;

    int cyc = 0;
    always @(posedge I_clk) cyc <= cyc + 1;

    // Behavioural ALU: shifts by n hold busy for n+1 cycles after the enable
    logic [4:0] r_cnt;
    always_comb begin
        I_alu_data = '0;
        case (O_alu_op)
            OP_ADD:  I_alu_data = O_alu_s1 + O_alu_s2;
            OP_SUB:  I_alu_data = O_alu_s1 - O_alu_s2;
            OP_OR:   I_alu_data = O_alu_s1 | O_alu_s2;
            OP_SLL:  I_alu_data = O_alu_s1 << O_alu_s2[4:0];
            OP_SRA:  I_alu_data = $signed(O_alu_s1) >>> O_alu_s2[4:0];
            default: I_alu_data = '0;
        endcase
    end
    assign I_alu_lt  = $signed(O_alu_s1) < $signed(O_alu_s2);
    assign I_alu_ltu = O_alu_s1 < O_alu_s2;
    assign I_alu_eq  = O_alu_s1 == O_alu_s2;

    always @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            I_alu_busy <= 1'b0;
            r_cnt      <= '0;
        end else if (O_alu_en && (O_alu_op == OP_SLL || O_alu_op == OP_SRA)) begin
            I_alu_busy <= 1'b1;
            r_cnt      <= O_alu_s2[4:0];
        end else if (I_alu_busy) begin
            if (r_cnt == 0) I_alu_busy <= 1'b0;
            else            r_cnt <= r_cnt - 5'd1;
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        lt, ltu, eq;
        int          cyc;
    } exp_t;

    typedef struct {
        string       name;
        logic [63:0] act;
        logic [63:0] exp;
    } dchk_t;

    exp_t  qa[$];
    exp_t  qb[$];
    dchk_t dq[$];
    bit    order[$];

    int checks = 0;
    int errors = 0;

    function automatic void dchk(input string n, input logic [63:0] a, input logic [63:0] e);
        dchk_t c;
        c.name = n; c.act = a; c.exp = e;
        dq.push_back(c);
    endfunction

    // Monitor: drains directed checks and compares every valid pulse against the scoreboard
    dchk_t m_c;
    exp_t  m_e;
    always @(negedge I_clk) begin
        while (dq.size() > 0) begin
            m_c = dq.pop_front();
            checks++;
            if (m_c.act !== m_c.exp) begin
                errors++;
                $display("FAIL %s: got %0h, expected %0h", m_c.name, m_c.act, m_c.exp);
            end
        end
        if (O_a_valid) begin
            checks++;
            if (qa.size() == 0) begin
                errors++;
                $display("FAIL a_valid_unexpected: got valid at cycle %0d, expected none", cyc);
            end else begin
                m_e = qa.pop_front();
                if ({O_a_data, O_a_lt, O_a_ltu, O_a_eq} !== {m_e.d, m_e.lt, m_e.ltu, m_e.eq} || cyc != m_e.cyc) begin
                    errors++;
                    $display("FAIL a_result: got data=%0h lt=%b ltu=%b eq=%b cyc=%0d, expected data=%0h lt=%b ltu=%b eq=%b cyc=%0d",
                             O_a_data, O_a_lt, O_a_ltu, O_a_eq, cyc, m_e.d, m_e.lt, m_e.ltu, m_e.eq, m_e.cyc);
                end
            end
        end
        if (O_b_valid) begin
            checks++;
            if (qb.size() == 0) begin
                errors++;
                $display("FAIL b_valid_unexpected: got valid at cycle %0d, expected none", cyc);
            end else begin
                m_e = qb.pop_front();
                if ({O_b_data, O_b_lt, O_b_ltu, O_b_eq} !== {m_e.d, m_e.lt, m_e.ltu, m_e.eq} || cyc != m_e.cyc) begin
                    errors++;
                    $display("FAIL b_result: got data=%0h lt=%b ltu=%b eq=%b cyc=%0d, expected data=%0h lt=%b ltu=%b eq=%b cyc=%0d",
                             O_b_data, O_b_lt, O_b_ltu, O_b_eq, cyc, m_e.d, m_e.lt, m_e.ltu, m_e.eq, m_e.cyc);
                end
            end
        end
        if (O_a_valid || O_b_valid) begin
            checks++;
            if (O_a_valid && O_b_valid) begin
                errors++;
                $display("FAIL valid_overlap: got both valids at cycle %0d, expected at most one", cyc);
            end
        end
    end

    // Drive a request on port p (0=A, 1=B) from a negedge until granted; returns grant cycle
    task automatic req(input bit p, input logic [4:0] op, input logic [31:0] s1,
                       input logic [31:0] s2, input bit chk, input logic [31:0] ed,
                       input bit elt, input bit eltu, input bit eeq, input int lat,
                       output int tg);
        bit   got;
        exp_t e;
        got = 1'b0;
        tg  = -1;
        if (!p) begin I_a_req = 1'b1; I_a_op = op; I_a_s1 = s1; I_a_s2 = s2; end
        else    begin I_b_req = 1'b1; I_b_op = op; I_b_s1 = s1; I_b_s2 = s2; end
        for (int i = 0; i < 200 && !got; i++) begin
            #1;
            if (p ? O_b_gnt : O_a_gnt) begin
                got = 1'b1;
                tg  = cyc;
                order.push_back(p);
                if (chk) begin
                    e.d = ed; e.lt = elt; e.ltu = eltu; e.eq = eeq; e.cyc = tg + lat;
                    if (!p) qa.push_back(e); else qb.push_back(e);
                end
            end else begin
                @(negedge I_clk);
            end
        end
        if (!got) dchk(p ? "b_gnt_timeout" : "a_gnt_timeout", 64'd0, 64'd1);
        @(negedge I_clk);
        if (!p) I_a_req = 1'b0; else I_b_req = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge I_clk);
        I_reset_n = 1'b0;
        repeat (2) @(negedge I_clk);
        I_reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  ta, tb;
        bit  hold_ok;
        logic [31:0] dsave;

        I_reset_n = 1'b0;
        I_a_req = 1'b0; I_a_kill = 1'b0; I_a_op = '0; I_a_s1 = '0; I_a_s2 = '0;
        I_b_req = 1'b0; I_b_kill = 1'b0; I_b_op = '0; I_b_s1 = '0; I_b_s2 = '0;
        repeat (2) @(negedge I_clk);
        dchk("rst_idle",    {63'd0, O_idle},    64'd1);
        dchk("rst_alu_en",  {63'd0, O_alu_en},  64'd0);
        dchk("rst_gnt",     {62'd0, O_a_gnt, O_b_gnt}, 64'd0);
        dchk("rst_valid",   {62'd0, O_a_valid, O_b_valid}, 64'd0);
        dchk("rst_held",    {27'd0, O_alu_op, O_alu_s1}, 64'd0);
        dchk("rst_results", {O_a_data, O_b_data}, 64'd0);
        I_reset_n = 1'b1;

        // Contention straight out of reset: A first, B on the return to IDLE
        fork
            req(1'b0, OP_SUB, 32'd3, 32'd3, 1'b1, 32'd0, 1'b0, 1'b0, 1'b1, 3, ta);
            req(1'b1, OP_OR, 32'hF0, 32'h0F, 1'b1, 32'hFF, 1'b0, 1'b0, 1'b0, 3, tb);
        join
        dchk("contend_b_after_a", tb - ta, 64'd3);

        // A only ADD
        req(1'b0, OP_ADD, 32'd5, 32'd7, 1'b1, 32'd12, 1'b1, 1'b1, 1'b0, 3, ta);
        dchk("alu_en_issue", {63'd0, O_alu_en}, 64'd1);
        @(negedge I_clk);
        dchk("alu_en_one_cycle", {63'd0, O_alu_en}, 64'd0);
        repeat (3) @(negedge I_clk);

        // B shift: operands held throughout busy, valid 8 cycles after grant
        req(1'b1, OP_SLL, 32'd1, 32'd4, 1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 8, tb);
        hold_ok = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (O_alu_op != OP_SLL || O_alu_s1 != 32'd1 || O_alu_s2 != 32'd4) hold_ok = 1'b0;
            @(negedge I_clk);
        end
        dchk("sll_operand_hold", {63'd0, hold_ok}, 64'd1);
        repeat (3) @(negedge I_clk);

        // A SRA killed mid-busy; B waits for the ALU to drain
        dsave = O_a_data;
        req(1'b0, OP_SRA, 32'h8000_0000, 32'd31, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, ta);
        fork
            req(1'b1, OP_ADD, 32'd4, 32'd4, 1'b1, 32'd8, 1'b0, 1'b0, 1'b1, 3, tb);
            begin
                repeat (9) @(negedge I_clk);
                I_a_kill = 1'b1;
                @(negedge I_clk);
                I_a_kill = 1'b0;
            end
        join
        dchk("kill_b_gnt_cycle", tb - ta, 64'd35);
        dchk("kill_a_data_kept", {32'd0, O_a_data}, {32'd0, dsave});
        repeat (4) @(negedge I_clk);

        // Continuous requests on both ports
        order.delete();
        fork
            begin
                req(1'b0, OP_ADD, 32'd10, 32'd20, 1'b1, 32'd30, 1'b1, 1'b1, 1'b0, 3, ta);
                req(1'b0, OP_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'd0, 1'b1, 1'b0, 1'b0, 3, ta);
                req(1'b0, OP_SUB, 32'd7, 32'd2, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 3, ta);
            end
            begin
                req(1'b1, OP_OR, 32'd1, 32'd2, 1'b1, 32'd3, 1'b1, 1'b1, 1'b0, 3, tb);
                req(1'b1, OP_SUB, 32'd2, 32'd7, 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b1, 1'b0, 3, tb);
                req(1'b1, OP_OR, 32'h8000_0000, 32'd1, 1'b1, 32'h8000_0001, 1'b1, 1'b0, 1'b0, 3, tb);
            end
        join
        dchk("rr_count", order.size(), 64'd6);
        for (int i = 0; i < order.size(); i++)
            dchk($sformatf("rr_order_%0d", i), {63'd0, order[i]}, {63'd0, i[0]});
        repeat (4) @(negedge I_clk);

        // Asynchronous reset while waiting on the ALU discards the op
        req(1'b0, OP_ADD, 32'd3, 32'd4, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 0, ta);
        @(negedge I_clk);
        #2 I_reset_n = 1'b0;
        #1;
        dchk("arst_idle",    {63'd0, O_idle},   64'd1);
        dchk("arst_alu_en",  {63'd0, O_alu_en}, 64'd0);
        dchk("arst_results", {O_a_data, O_b_data}, 64'd0);
        dchk("arst_held",    {27'd0, O_alu_op, O_alu_s1}, 64'd0);
        @(negedge I_clk);
        I_reset_n = 1'b1;
        req(1'b0, OP_ADD, 32'd1, 32'd1, 1'b1, 32'd2, 1'b0, 1'b0, 1'b1, 3, ta);
        repeat (6) @(negedge I_clk);

        dchk("a_queue_drained", qa.size(), 64'd0);
        dchk("b_queue_drained", qb.size(), 64'd0);
        repeat (3) @(negedge I_clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
